// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl: keypad sequencing controller for the digital door lock.
// Collects a fixed-length BCD code, checks it against the stored password,
// drives the door-open output with auto-relock, counts failed attempts,
// enforces a timed lockout with alarm, and allows a password change while
// the door is open. All timers advance only on the divider's tick enable.
module doorlock_ctrl #(
  parameter int                  PW_LEN      = 4,
  parameter logic [4*PW_LEN-1:0] DEFAULT_PW  = 16'h1234,
  parameter int                  OPEN_TICKS  = 50,
  parameter int                  ENTRY_TICKS = 100,
  parameter int                  LOCK_TICKS  = 300,
  parameter int                  MAX_FAIL    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ps_start,
  input  logic [3:0] ps_num,
  input  logic       ps_num_valid,
  input  logic       ps_end,
  output logic       door_open,
  output logic       alarm,
  output logic       err,
  output logic [2:0] state_out,
  output logic [3:0] digit_cnt,
  output logic [1:0] fail_cnt
);

  localparam int PW_W   = 4 * PW_LEN;
  localparam int T_OE   = (OPEN_TICKS > ENTRY_TICKS) ? OPEN_TICKS : ENTRY_TICKS;
  localparam int T_MAX  = (T_OE > LOCK_TICKS) ? T_OE : LOCK_TICKS;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_NEWPW   = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  state_t           state, state_d;
  logic [PW_W-1:0]  stored_pw, stored_pw_d;
  logic [PW_W-1:0]  pw_buf, pw_buf_d;
  logic [3:0]       digit_cnt_d;
  logic [1:0]       fail_cnt_d;
  logic [TMR_W-1:0] timer, timer_d;
  logic             err_d;

  logic             dig_accept;
  logic             dig_bad;
  logic [PW_W-1:0]  pw_buf_shift;
  logic             buf_full;

  // Saturating increment of the 2-bit failure counter.
  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? 2'd3 : v + 2'd1;
  endfunction

  // True when this tick is the last one of an N-tick interval.
  function automatic logic tmr_done(input logic [TMR_W-1:0] t, input int n);
    return (t == TMR_W'(n - 1));
  endfunction

  // Digit classification shared by ENTRY and NEWPW capture.
  always_comb begin
    buf_full     = (digit_cnt >= 4'(PW_LEN));
    dig_accept   = ps_num_valid && (ps_num <= 4'd9) && !buf_full;
    dig_bad      = ps_num_valid && (ps_num > 4'd9);
    pw_buf_shift = (pw_buf << 4) | PW_W'(ps_num);
  end

  // Next-state, datapath update and error pulse decode.
  always_comb begin
    state_d     = state;
    stored_pw_d = stored_pw;
    pw_buf_d    = pw_buf;
    digit_cnt_d = digit_cnt;
    fail_cnt_d  = fail_cnt;
    timer_d     = timer;
    err_d       = 1'b0;

    case (state)
      S_IDLE: begin
        if (ps_start) begin
          pw_buf_d    = '0;
          digit_cnt_d = 4'd0;
          state_d     = S_ENTRY;
        end
      end

      S_ENTRY, S_NEWPW: begin
        if (ps_end) begin
          if (state == S_ENTRY) begin
            if (buf_full && (pw_buf == stored_pw)) begin
              state_d    = S_OPEN;
              fail_cnt_d = 2'd0;
            end else begin
              state_d    = S_FAIL;
              fail_cnt_d = sat_inc2(fail_cnt);
              err_d      = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
            if (buf_full) stored_pw_d = pw_buf;
            else          err_d       = 1'b1;
          end
        end else if (ps_start) begin
          // Start key mid-entry has no action but still counts as activity.
          timer_d = '0;
        end else if (ps_num_valid) begin
          timer_d = '0;
          if (dig_accept) begin
            pw_buf_d    = pw_buf_shift;
            digit_cnt_d = digit_cnt + 4'd1;
          end
          if (dig_bad) err_d = 1'b1;
        end else if (tick) begin
          if (tmr_done(timer, ENTRY_TICKS)) state_d = S_IDLE;
          else                              timer_d = timer + 1'b1;
        end
      end

      S_OPEN: begin
        if (ps_end) begin
          state_d = S_IDLE;
        end else if (ps_start) begin
          pw_buf_d    = '0;
          digit_cnt_d = 4'd0;
          state_d     = S_NEWPW;
        end else if (tick) begin
          if (tmr_done(timer, OPEN_TICKS)) state_d = S_IDLE;
          else                             timer_d = timer + 1'b1;
        end
      end

      S_FAIL: begin
        state_d = (fail_cnt >= 2'(MAX_FAIL)) ? S_LOCKOUT : S_IDLE;
      end

      S_LOCKOUT: begin
        if (tick) begin
          if (tmr_done(timer, LOCK_TICKS)) begin
            state_d    = S_IDLE;
            fail_cnt_d = 2'd0;
          end else begin
            timer_d = timer + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Every state entry starts its interval from zero.
    if (state_d != state) timer_d = '0;
  end

  // State, datapath and registered outputs; reset restores the default password.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      stored_pw <= DEFAULT_PW;
      pw_buf    <= '0;
      digit_cnt <= 4'd0;
      fail_cnt  <= 2'd0;
      timer     <= '0;
      err       <= 1'b0;
      door_open <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      state     <= state_d;
      stored_pw <= stored_pw_d;
      pw_buf    <= pw_buf_d;
      digit_cnt <= digit_cnt_d;
      fail_cnt  <= fail_cnt_d;
      timer     <= timer_d;
      err       <= err_d;
      door_open <= (state_d == S_OPEN);
      alarm     <= (state_d == S_LOCKOUT);
    end
  end

  assign state_out = state;

endmodule
